// File: rtl/key_schedule_controller.sv
// AES key-schedule controller: iterates one KeyExpansionRound over a held key block
// and streams round keys 0..Nr on a valid/ready interface.

module KeyExpansionRound #(
  parameter int Nk = 4
) (
  input  logic [32*Nk-1:0] keyIn,
  input  logic [3:0]       roundCount,
  output logic [32*Nk-1:0] keyOut
);

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] prod;
    logic [7:0] acc;
    prod = 8'h00;
    acc  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) prod = prod ^ acc;
      acc = {acc[6:0], 1'b0} ^ (acc[7] ? 8'h1b : 8'h00);
    end
    return prod;
  endfunction

  // S-box as GF(2^8) inverse (x^254, so 0 maps to 0) followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] pw;
    logic [7:0] inv;
    pw  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      pw  = gmul(pw, pw);
      inv = gmul(inv, pw);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subWord(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] rc);
    case (rc)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Each new word chains off the previous new word; for Nk=8 word 4 adds a second S-box level.
  always_comb begin
    logic [31:0] prev;
    logic [31:0] temp;
    logic [31:0] w;
    // NOTE: every variable written here gets a value on every path, so no latch is inferred.
    keyOut = '0;
    prev   = keyIn[31:0];
    for (int i = 0; i < Nk; i++) begin
      w = keyIn[32*(Nk-1-i) +: 32];
      if (i == 0)
        temp = subWord({prev[23:0], prev[31:24]}) ^ {rcon(roundCount), 24'h000000};
      else if (Nk == 8 && i == 4)
        temp = subWord(prev);
      else
        temp = prev;
      prev = w ^ temp;
      keyOut[32*(Nk-1-i) +: 32] = prev;
    end
  end

endmodule

module key_schedule_controller #(
  parameter int Nk = 4,
  parameter int Nr = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [32*Nk-1:0]  keyIn,
  input  logic              abort,
  output logic              busy,
  output logic              rkValid,
  input  logic              rkReady,
  output logic [127:0]      roundKey,
  output logic [3:0]        rkIndex,
  output logic              done
);

  localparam int KeyBits = 32 * Nk;

  typedef enum logic {IDLE, EMIT} ctrlState;

  ctrlState           state;
  logic [KeyBits-1:0] keyReg;
  logic [KeyBits-1:0] keyOut;
  logic [3:0]         iter;
  logic               half;
  logic               advanceBlock;

  KeyExpansionRound #(.Nk(Nk)) expander (
    .keyIn      (keyReg),
    .roundCount (iter + 4'd1),
    .keyOut     (keyOut)
  );

  // Nk=8 emits each 256-bit block as two round keys; only the second one advances the block.
  assign advanceBlock = (Nk == 4) || half;
  assign roundKey     = (Nk == 8 && half) ? keyReg[127:0] : keyReg[KeyBits-1 -: 128];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      rkValid <= 1'b0;
      done    <= 1'b0;
      rkIndex <= 4'd0;
      keyReg  <= '0;
      iter    <= 4'd0;
      half    <= 1'b0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= EMIT;
            busy    <= 1'b1;
            rkValid <= 1'b1;
            keyReg  <= keyIn;
            iter    <= 4'd0;
            half    <= 1'b0;
            rkIndex <= 4'd0;
          end
        end
        EMIT: begin
          if (abort) begin
            state   <= IDLE;
            busy    <= 1'b0;
            rkValid <= 1'b0;
          end else if (rkValid && rkReady) begin
            if (rkIndex == 4'(Nr)) begin
              state   <= IDLE;
              busy    <= 1'b0;
              rkValid <= 1'b0;
              done    <= 1'b1;
            end else begin
              rkIndex <= rkIndex + 4'd1;
              if (advanceBlock) begin
                keyReg <= keyOut;
                iter   <= iter + 4'd1;
                half   <= 1'b0;
              end else begin
                half <= 1'b1;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_schedule_controller.sv
// Directed bench for key_schedule_controller: AES-128 and AES-256 schedules,
// backpressure, ignored start, abort, and asynchronous reset mid-run.

module tb_key_schedule_controller;

  localparam logic [127:0] Key128   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] Other128 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] Key256   =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic [127:0] exp128 [0:10] = '{
    128'h2b7e151628aed2a6abf7158809cf4f3c,
    128'ha0fafe1788542cb123a339392a6c7605,
    128'hf2c295f27a96b9435935807a7359f67f,
    128'h3d80477d4716fe3e1e237e446d7a883b,
    128'hef44a541a8525b7fb671253bdb0bad00,
    128'hd4d1c6f87c839d87caf2b8bc11f915bc,
    128'h6d88a37a110b3efddbf98641ca0093fd,
    128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
    128'head27321b58dbad2312bf5607f8d292f,
    128'hac7766f319fadc2128d12941575c006e,
    128'hd014f9a8c9ee2589e13f0cc8b6630ca6
  };

  logic         clk;
  logic         rst_n;
  logic         start128, abort128, rkReady128;
  logic [127:0] keyIn128;
  logic         busy128, rkValid128, done128;
  logic [127:0] roundKey128;
  logic [3:0]   rkIndex128;

  logic         start256, abort256, rkReady256;
  logic [255:0] keyIn256;
  logic         busy256, rkValid256, done256;
  logic [127:0] roundKey256;
  logic [3:0]   rkIndex256;

  int checks = 0;
  int errors = 0;

  key_schedule_controller #(.Nk(4), .Nr(10)) dut128 (
    .clk(clk), .rst_n(rst_n), .start(start128), .keyIn(keyIn128), .abort(abort128),
    .busy(busy128), .rkValid(rkValid128), .rkReady(rkReady128),
    .roundKey(roundKey128), .rkIndex(rkIndex128), .done(done128)
  );

  key_schedule_controller #(.Nk(8), .Nr(14)) dut256 (
    .clk(clk), .rst_n(rst_n), .start(start256), .keyIn(keyIn256), .abort(abort256),
    .busy(busy256), .rkValid(rkValid256), .rkReady(rkReady256),
    .roundKey(roundKey256), .rkIndex(rkIndex256), .done(done256)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // mode: 0 plain, 1 backpressure, 2 start while busy, 3 abort at rk5,
  //       4 reset at rk7, 5 start together with abort in IDLE
  task automatic run128(input int mode, input bit preStarted, input bit chainNext);
    logic [15:0] pattern;
    int  expIdx, hs, doneCyc;
    bit  gotDone, ended, rdy;
    pattern = 16'b1011_0010_1110_0100;
    if (!preStarted) begin
      @(negedge clk);
      keyIn128   = Key128;
      start128   = 1'b1;
      abort128   = (mode == 5);
      rkReady128 = 1'b0;
    end
    expIdx = 0; hs = 0; doneCyc = -1; gotDone = 0; ended = 0;
    for (int cyc = 0; cyc < 100 && !gotDone && !ended; cyc++) begin
      @(negedge clk);
      start128 = 1'b0;
      abort128 = 1'b0;
      if (done128) begin
        gotDone = 1;
        doneCyc = cyc;
        rkReady128 = 1'b0;
        check("busy_at_done", busy128, 0);
        check("valid_at_done", rkValid128, 0);
        if (chainNext) begin
          keyIn128 = Key128;
          start128 = 1'b1;
        end
      end else begin
        check("valid128", rkValid128, 1);
        check("busy128", busy128, 1);
        check("idx128", rkIndex128, expIdx[3:0]);
        check("rk128", roundKey128, exp128[expIdx > 10 ? 10 : expIdx]);
        rdy = (mode == 1) ? pattern[cyc % 16] : 1'b1;
        rkReady128 = rdy;
        if (mode == 2 && expIdx == 3) begin
          keyIn128 = Other128;
          start128 = 1'b1;
        end
        if (mode == 3 && expIdx == 5) begin
          abort128   = 1'b1;
          rkReady128 = 1'b1;
          ended      = 1;
        end else if (mode == 4 && expIdx == 7) begin
          #1 rst_n = 1'b0;
          #1;
          check("rst_busy", busy128, 0);
          check("rst_valid", rkValid128, 0);
          check("rst_done", done128, 0);
          check("rst_idx", rkIndex128, 0);
          check("rst_rk", roundKey128, 0);
          ended = 1;
        end else if (rdy) begin
          expIdx++;
          hs++;
        end
      end
    end
    if (mode == 3) begin
      @(negedge clk);
      abort128 = 1'b0;
      rkReady128 = 1'b0;
      check("abort_valid", rkValid128, 0);
      check("abort_busy", busy128, 0);
      check("abort_done", done128, 0);
      @(negedge clk);
      check("abort_no_done", done128, 0);
    end else if (mode == 4) begin
      rkReady128 = 1'b0;
      @(negedge clk);
      check("rst_hold_valid", rkValid128, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_busy", busy128, 0);
      check("post_rst_valid", rkValid128, 0);
      check("post_rst_idx", rkIndex128, 0);
    end else begin
      check("done_seen", gotDone, 1);
      check("handshakes128", hs, 11);
      if (mode != 1) check("done_cycle", doneCyc, 11);
      if (!chainNext) begin
        @(negedge clk);
        check("done_one_pulse", done128, 0);
      end
    end
  endtask

  initial begin
    int  e, hs;
    bit  got;
    rst_n = 1'b0;
    start128 = 1'b0; abort128 = 1'b0; rkReady128 = 1'b0; keyIn128 = '0;
    start256 = 1'b0; abort256 = 1'b0; rkReady256 = 1'b0; keyIn256 = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", busy128, 0);
    check("reset_valid", rkValid128, 0);
    check("reset_done", done128, 0);
    check("reset_idx", rkIndex128, 0);
    check("reset_rk", roundKey128, 0);
    check("reset_rk256", roundKey256, 0);
    rst_n = 1'b1;

    run128(0, 1'b0, 1'b1);
    run128(0, 1'b1, 1'b0);
    run128(1, 1'b0, 1'b0);
    run128(2, 1'b0, 1'b0);
    run128(3, 1'b0, 1'b0);
    run128(5, 1'b0, 1'b0);
    run128(4, 1'b0, 1'b0);
    run128(0, 1'b0, 1'b0);

    @(negedge clk);
    keyIn256 = Key256;
    start256 = 1'b1;
    e = 0; hs = 0; got = 0;
    for (int cyc = 0; cyc < 60 && !got; cyc++) begin
      @(negedge clk);
      start256 = 1'b0;
      if (done256) begin
        got = 1;
        rkReady256 = 1'b0;
        check("valid256_at_done", rkValid256, 0);
      end else begin
        check("valid256", rkValid256, 1);
        check("idx256", rkIndex256, e[3:0]);
        case (e)
          0:  check("rk256_0", roundKey256, Key256[255:128]);
          1:  check("rk256_1", roundKey256, Key256[127:0]);
          2:  check("rk256_2", roundKey256, 128'h9ba354118e6925afa51a8b5f2067fcde);
          14: check("rk256_14", roundKey256, 128'hfe4890d1e6188d0b046df344706c631e);
          default: ;
        endcase
        rkReady256 = 1'b1;
        e++;
        hs++;
      end
    end
    check("done256_seen", got, 1);
    check("handshakes256", hs, 15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
